// File: rtl/trex_pkg.sv
// Shared constants and types for the T-rex game datapath: screen coordinates,
// sprite box sizes and the collision detector state encoding.
package trex_pkg;

  localparam int unsigned COORD_W     = 10;
  localparam int unsigned DINO_W      = 32;
  localparam int unsigned DINO_H      = 32;
  localparam int unsigned OBS_W       = 16;
  localparam int unsigned OBS_H       = 32;
  localparam int unsigned OVL_CNT_W   = 4;
  localparam int unsigned OVL_CNT_MAX = 15;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRACE = 2'd1,
    TRACK = 2'd2,
    HIT   = 2'd3
  } cd_state_t;

endpackage

// File: rtl/collision_detector_if.sv
// Position/control bundle from the sprite logic and game FSM into the
// collision detector, plus its hit outputs.
interface collision_detector_if;

  logic              start;
  logic              run;
  logic              frame_tick;
  trex_pkg::coord_t  dino_x;
  trex_pkg::coord_t  dino_y;
  trex_pkg::coord_t  obs_x;
  trex_pkg::coord_t  obs_y;
  logic              obs_valid;
  logic              collided;
  logic              hit_pulse;

  modport master (
    output start, run, frame_tick, dino_x, dino_y, obs_x, obs_y, obs_valid,
    input  collided, hit_pulse
  );

  modport slave (
    input  start, run, frame_tick, dino_x, dino_y, obs_x, obs_y, obs_valid,
    output collided, hit_pulse
  );

endinterface

// File: rtl/collision_detector_bbox_overlap.sv
// Combinational axis-aligned box overlap test; edge-touching boxes do not
// overlap. Far edges are formed one bit wider so they never wrap.
module bbox_overlap #(
  parameter int unsigned COORD_W = 10,
  parameter int unsigned A_W     = 32,
  parameter int unsigned A_H     = 32,
  parameter int unsigned B_W     = 16,
  parameter int unsigned B_H     = 32
) (
  input  logic [COORD_W-1:0] a_x,
  input  logic [COORD_W-1:0] a_y,
  input  logic [COORD_W-1:0] b_x,
  input  logic [COORD_W-1:0] b_y,
  output logic               overlap_c
);

  localparam int unsigned SUM_W = COORD_W + 1;

  logic [SUM_W-1:0] a_x_ext, a_y_ext, b_x_ext, b_y_ext;
  logic [SUM_W-1:0] a_right, a_bottom, b_right, b_bottom;

  always_comb begin
    a_x_ext   = SUM_W'(a_x);
    a_y_ext   = SUM_W'(a_y);
    b_x_ext   = SUM_W'(b_x);
    b_y_ext   = SUM_W'(b_y);
    a_right   = a_x_ext + SUM_W'(A_W);
    a_bottom  = a_y_ext + SUM_W'(A_H);
    b_right   = b_x_ext + SUM_W'(B_W);
    b_bottom  = b_y_ext + SUM_W'(B_H);
    overlap_c = (a_x_ext < b_right) && (b_x_ext < a_right) &&
                (a_y_ext < b_bottom) && (b_y_ext < a_bottom);
  end

endmodule

// File: rtl/collision_detector.sv
// Per-frame dino/obstacle collision detector with consecutive-frame filter and
// sticky hit flag. Optional start-of-run immunity under COLLISION_GRACE_EN.
module collision_detector
  import trex_pkg::*;
#(
  parameter int unsigned DINO_W         = trex_pkg::DINO_W,
  parameter int unsigned DINO_H         = trex_pkg::DINO_H,
  parameter int unsigned OBS_W          = trex_pkg::OBS_W,
  parameter int unsigned OBS_H          = trex_pkg::OBS_H,
  parameter int unsigned OVERLAP_FRAMES = 2
`ifdef COLLISION_GRACE_EN
  ,
  parameter int unsigned GRACE_FRAMES   = 60
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  collision_detector_if.slave  bus
);

  cd_state_t              state_q, state_d;
  coord_t                 dino_x_q, dino_x_d, dino_y_q, dino_y_d;
  coord_t                 obs_x_q, obs_x_d, obs_y_q, obs_y_d;
  logic                   obs_valid_q, obs_valid_d;
  logic                   sample_vld_q, sample_vld_d;
  logic [OVL_CNT_W-1:0]   ovl_cnt_q, ovl_cnt_d, ovl_next;
  logic                   collided_q, collided_d;
  logic                   hit_pulse_q, hit_pulse_d;
  logic                   overlap_c;

`ifdef COLLISION_GRACE_EN
  localparam int unsigned GRACE_W = (GRACE_FRAMES > 1) ? $clog2(GRACE_FRAMES) : 1;
  logic [GRACE_W-1:0]     grace_cnt_q, grace_cnt_d;
`endif

  bbox_overlap #(
    .COORD_W (COORD_W),
    .A_W     (DINO_W),
    .A_H     (DINO_H),
    .B_W     (OBS_W),
    .B_H     (OBS_H)
  ) u_overlap (
    .a_x       (dino_x_q),
    .a_y       (dino_y_q),
    .b_x       (obs_x_q),
    .b_y       (obs_y_q),
    .overlap_c (overlap_c)
  );

  // Next state: start=0 overrides the FSM; stage 2 runs on the cycle after a tick.
  always_comb begin
    state_d      = state_q;
    dino_x_d     = dino_x_q;
    dino_y_d     = dino_y_q;
    obs_x_d      = obs_x_q;
    obs_y_d      = obs_y_q;
    obs_valid_d  = obs_valid_q;
    sample_vld_d = 1'b0;
    ovl_cnt_d    = ovl_cnt_q;
    ovl_next     = ovl_cnt_q;
    collided_d   = collided_q;
    hit_pulse_d  = 1'b0;
`ifdef COLLISION_GRACE_EN
    grace_cnt_d  = grace_cnt_q;
`endif

    if (!bus.start) begin
      state_d     = IDLE;
      dino_x_d    = '0;
      dino_y_d    = '0;
      obs_x_d     = '0;
      obs_y_d     = '0;
      obs_valid_d = 1'b0;
      ovl_cnt_d   = '0;
      collided_d  = 1'b0;
`ifdef COLLISION_GRACE_EN
      grace_cnt_d = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          collided_d = 1'b0;
          ovl_cnt_d  = '0;
          if (bus.run) begin
`ifdef COLLISION_GRACE_EN
            state_d     = GRACE;
            grace_cnt_d = '0;
`else
            state_d     = TRACK;
`endif
          end
        end
`ifdef COLLISION_GRACE_EN
        GRACE: begin
          if (!bus.run) begin
            state_d     = IDLE;
            grace_cnt_d = '0;
          end else if (bus.frame_tick) begin
            if (grace_cnt_q == GRACE_W'(GRACE_FRAMES - 1)) begin
              state_d     = TRACK;
              grace_cnt_d = '0;
            end else begin
              grace_cnt_d = grace_cnt_q + GRACE_W'(1);
            end
          end
        end
`endif
        TRACK: begin
          if (!bus.run) begin
            state_d   = IDLE;
            ovl_cnt_d = '0;
          end else begin
            if (bus.frame_tick) begin
              dino_x_d     = bus.dino_x;
              dino_y_d     = bus.dino_y;
              obs_x_d      = bus.obs_x;
              obs_y_d      = bus.obs_y;
              obs_valid_d  = bus.obs_valid;
              sample_vld_d = 1'b1;
            end
            if (sample_vld_q) begin
              if (overlap_c && obs_valid_q) begin
                ovl_next = (ovl_cnt_q == OVL_CNT_W'(OVL_CNT_MAX)) ? ovl_cnt_q
                                                                   : ovl_cnt_q + OVL_CNT_W'(1);
              end else begin
                ovl_next = '0;
              end
              ovl_cnt_d = ovl_next;
              if (ovl_next >= OVL_CNT_W'(OVERLAP_FRAMES)) begin
                state_d     = HIT;
                collided_d  = 1'b1;
                hit_pulse_d = 1'b1;
              end
            end
          end
        end
        HIT: begin
          collided_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      dino_x_q     <= '0;
      dino_y_q     <= '0;
      obs_x_q      <= '0;
      obs_y_q      <= '0;
      obs_valid_q  <= 1'b0;
      sample_vld_q <= 1'b0;
      ovl_cnt_q    <= '0;
      collided_q   <= 1'b0;
      hit_pulse_q  <= 1'b0;
`ifdef COLLISION_GRACE_EN
      grace_cnt_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      dino_x_q     <= dino_x_d;
      dino_y_q     <= dino_y_d;
      obs_x_q      <= obs_x_d;
      obs_y_q      <= obs_y_d;
      obs_valid_q  <= obs_valid_d;
      sample_vld_q <= sample_vld_d;
      ovl_cnt_q    <= ovl_cnt_d;
      collided_q   <= collided_d;
      hit_pulse_q  <= hit_pulse_d;
`ifdef COLLISION_GRACE_EN
      grace_cnt_q  <= grace_cnt_d;
`endif
    end
  end

  assign bus.collided  = collided_q;
  assign bus.hit_pulse = hit_pulse_q;

endmodule

// File: tb/tb_collision_detector.sv
// Directed bench for collision_detector: box-geometry vector table plus
// hand-written timing, stickiness, reset and (optional) grace sequences.
module tb_collision_detector;
  import trex_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  collision_detector_if bus ();

  collision_detector #(
    .OVERLAP_FRAMES (2)
`ifdef COLLISION_GRACE_EN
    ,
    .GRACE_FRAMES   (3)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  typedef struct {
    string      name;
    logic [9:0] dx;
    logic [9:0] dy;
    logic [9:0] ox;
    logic [9:0] oy;
    logic       v;
    int         ticks;
    logic       exp;
  } vec_t;

  vec_t vecs[12];

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_pos(input logic [9:0] dx, input logic [9:0] dy,
                         input logic [9:0] ox, input logic [9:0] oy, input logic v);
    bus.dino_x    = dx;
    bus.dino_y    = dy;
    bus.obs_x     = ox;
    bus.obs_y     = oy;
    bus.obs_valid = v;
  endtask

  // One frame tick followed by enough idle cycles for stage 2 and the output flop.
  task automatic tick();
    bus.frame_tick = 1'b1;
    cyc(1);
    bus.frame_tick = 1'b0;
    cyc(3);
  endtask

  // Restart a run and leave the DUT tracking.
  task automatic begin_run();
    bus.start = 1'b0;
    bus.run   = 1'b0;
    cyc(1);
    bus.start = 1'b1;
    bus.run   = 1'b1;
    cyc(1);
`ifdef COLLISION_GRACE_EN
    set_pos(10'd100, 10'd400, 10'd500, 10'd100, 1'b0);
    repeat (3) tick();
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = '{"basic_hit",     10'd100,  10'd400, 10'd120,  10'd400, 1'b1, 2, 1'b1};
    vecs[1]  = '{"right_touch",   10'd100,  10'd400, 10'd132,  10'd400, 1'b1, 4, 1'b0};
    vecs[2]  = '{"right_1px",     10'd100,  10'd400, 10'd131,  10'd400, 1'b1, 2, 1'b1};
    vecs[3]  = '{"left_touch",    10'd100,  10'd400, 10'd84,   10'd400, 1'b1, 4, 1'b0};
    vecs[4]  = '{"left_1px",      10'd100,  10'd400, 10'd85,   10'd400, 1'b1, 2, 1'b1};
    vecs[5]  = '{"below_touch",   10'd100,  10'd400, 10'd110,  10'd432, 1'b1, 4, 1'b0};
    vecs[6]  = '{"above_touch",   10'd100,  10'd400, 10'd110,  10'd368, 1'b1, 4, 1'b0};
    vecs[7]  = '{"above_1px",     10'd100,  10'd400, 10'd110,  10'd369, 1'b1, 2, 1'b1};
    vecs[8]  = '{"invalid_obs",   10'd100,  10'd400, 10'd120,  10'd400, 1'b0, 4, 1'b0};
    vecs[9]  = '{"single_frame",  10'd100,  10'd400, 10'd120,  10'd400, 1'b1, 1, 1'b0};
    vecs[10] = '{"edge_no_wrap",  10'd1000, 10'd400, 10'd1020, 10'd400, 1'b1, 2, 1'b1};
    vecs[11] = '{"far_apart",     10'd1010, 10'd10,  10'd5,    10'd10,  1'b1, 4, 1'b0};

    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.run        = 1'b0;
    bus.frame_tick = 1'b0;
    set_pos('0, '0, '0, '0, 1'b0);
    cyc(2);
    chk("reset_collided", bus.collided, 1'b0);
    chk("reset_hit_pulse", bus.hit_pulse, 1'b0);
    chk_int("reset_ovl_cnt", int'(dut.ovl_cnt_q), 0);
    reset = 1'b0;
    cyc(1);

`ifdef COLLISION_GRACE_EN
    // Grace: first three overlapping frames ignored, frames 4 and 5 hit.
    bus.start = 1'b1;
    bus.run   = 1'b1;
    cyc(1);
    set_pos(10'd100, 10'd400, 10'd120, 10'd400, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("grace_ignored", bus.collided, 1'b0);
    end
    tick();
    chk("grace_tick4", bus.collided, 1'b0);
    tick();
    chk("grace_tick5", bus.collided, 1'b1);
`endif

    // Geometry table.
    for (int i = 0; i < 12; i++) begin
      begin_run();
      set_pos(vecs[i].dx, vecs[i].dy, vecs[i].ox, vecs[i].oy, vecs[i].v);
      for (int t = 0; t < vecs[i].ticks; t++) tick();
      chk(vecs[i].name, bus.collided, vecs[i].exp);
    end

    // Exact latency and single-cycle hit_pulse on the qualifying tick.
    begin_run();
    set_pos(10'd100, 10'd400, 10'd120, 10'd400, 1'b1);
    tick();
    bus.frame_tick = 1'b1;
    cyc(1);
    bus.frame_tick = 1'b0;
    chk("lat_t1_collided", bus.collided, 1'b0);
    cyc(1);
    chk("lat_t2_collided", bus.collided, 1'b1);
    chk("lat_t2_hit_pulse", bus.hit_pulse, 1'b1);
    cyc(1);
    chk("lat_t3_hit_pulse", bus.hit_pulse, 1'b0);
    chk("lat_t3_collided", bus.collided, 1'b1);

    // Sticky through run=0 and moved obstacle; start=0 clears next cycle.
    bus.run = 1'b0;
    set_pos(10'd100, 10'd400, 10'd600, 10'd10, 1'b1);
    tick();
    tick();
    chk("sticky_collided", bus.collided, 1'b1);
    chk("sticky_no_pulse", bus.hit_pulse, 1'b0);
    bus.start = 1'b0;
    cyc(1);
    chk("start_low_collided", bus.collided, 1'b0);
    chk("start_low_idle", dut.state_q == IDLE, 1'b1);

    // Alternating overlap / gap never reaches two consecutive frames.
    begin_run();
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) set_pos(10'd100, 10'd400, 10'd120, 10'd400, 1'b1);
      else            set_pos(10'd100, 10'd400, 10'd132, 10'd400, 1'b1);
      tick();
      chk("alternate", bus.collided, 1'b0);
    end

    // Reset between a qualifying tick and its stage 2.
    begin_run();
    set_pos(10'd100, 10'd400, 10'd120, 10'd400, 1'b1);
    tick();
    chk_int("pre_reset_cnt", int'(dut.ovl_cnt_q), 1);
    bus.frame_tick = 1'b1;
    cyc(1);
    bus.frame_tick = 1'b0;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("mid_reset_collided", bus.collided, 1'b0);
    chk("mid_reset_pulse", bus.hit_pulse, 1'b0);
    chk_int("mid_reset_cnt", int'(dut.ovl_cnt_q), 0);
    chk("mid_reset_sample", dut.sample_vld_q, 1'b0);
    cyc(2);
    chk("post_reset_collided", bus.collided, 1'b0);

    // run=0 in TRACK discards the in-flight sample.
    begin_run();
    set_pos(10'd100, 10'd400, 10'd120, 10'd400, 1'b1);
    tick();
    bus.frame_tick = 1'b1;
    cyc(1);
    bus.frame_tick = 1'b0;
    bus.run = 1'b0;
    cyc(2);
    chk("run_drop_collided", bus.collided, 1'b0);
    chk_int("run_drop_cnt", int'(dut.ovl_cnt_q), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
